// File: rtl/arb_pkg.sv
// Shared constants and state encoding for the 8-way round-robin bus arbiter.
package arb_pkg;

    localparam int unsigned N_REQ = 8;
    localparam int unsigned SELW  = 3;
    localparam int unsigned CNTW  = 4;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } arb_state_e;

endpackage

// File: rtl/mux8to1_32.sv
// Plain 8:1 multiplexer for 32-bit data words.
module mux8to1_32 (
    input  logic [31:0] x0,
    input  logic [31:0] x1,
    input  logic [31:0] x2,
    input  logic [31:0] x3,
    input  logic [31:0] x4,
    input  logic [31:0] x5,
    input  logic [31:0] x6,
    input  logic [31:0] x7,
    input  logic [2:0]  sel,
    output logic [31:0] y
);

    always_comb begin
        y = '0;
        unique case (sel)
            3'd0: y = x0;
            3'd1: y = x1;
            3'd2: y = x2;
            3'd3: y = x3;
            3'd4: y = x4;
            3'd5: y = x5;
            3'd6: y = x6;
            3'd7: y = x7;
            default: y = '0;
        endcase
    end

endmodule

// File: rtl/rr_pick8.sv
// Rotating-priority encoder: first set request found scanning ptr, ptr+1, ... mod 8.
module rr_pick8
    import arb_pkg::*;
(
    input  logic [N_REQ-1:0] req,
    input  logic [SELW-1:0]  ptr,
    output logic             found,
    output logic [SELW-1:0]  idx
);

    logic [SELW-1:0] cand;

    // Scan from the farthest offset down so the nearest hit to ptr is written last.
    always_comb begin
        found = 1'b0;
        idx   = '0;
        cand  = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            cand = ptr + SELW'(k);
            if (req[cand]) begin
                found = 1'b1;
                idx   = cand;
            end
        end
    end

endmodule

// File: rtl/rr_bus_arbiter8.sv
// Round-robin arbiter sharing one 32-bit datapath between 8 requesters; grants held per burst.
module rr_bus_arbiter8
    import arb_pkg::*;
#(
    parameter int unsigned DW       = 32,
    parameter int unsigned MAX_HOLD = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_REQ-1:0] req,
    input  logic [N_REQ-1:0] last,
    input  logic [DW-1:0]    x0,
    input  logic [DW-1:0]    x1,
    input  logic [DW-1:0]    x2,
    input  logic [DW-1:0]    x3,
    input  logic [DW-1:0]    x4,
    input  logic [DW-1:0]    x5,
    input  logic [DW-1:0]    x6,
    input  logic [DW-1:0]    x7,
    input  logic             o_ready,
    output logic [N_REQ-1:0] grant,
    output logic [SELW-1:0]  sel,
    output logic             o_valid,
    output logic [DW-1:0]    o_data,
    output logic             o_last
);

    if (MAX_HOLD == 0 || MAX_HOLD > 15) begin : g_bad_max_hold
        $error("rr_bus_arbiter8: MAX_HOLD must be in 1..15");
    end
    if (DW != 32) begin : g_bad_dw
        $error("rr_bus_arbiter8: DW must be 32 to match the mux instance");
    end

    localparam logic [CNTW-1:0] MaxHoldC = CNTW'(MAX_HOLD);

    arb_state_e       state_q, state_d;
    logic [N_REQ-1:0] grant_q, grant_d;
    logic [SELW-1:0]  sel_q, sel_d;
    logic [SELW-1:0]  ptr_q, ptr_d;
    logic [CNTW-1:0]  cnt_q, cnt_d;

    logic             pick_found;
    logic [SELW-1:0]  pick_idx;
    logic             busy;
    logic             xfer;
    logic [CNTW-1:0]  cnt_inc;

    rr_pick8 u_pick (
        .req   (req),
        .ptr   (ptr_q),
        .found (pick_found),
        .idx   (pick_idx)
    );

    mux8to1_32 u_mux (
        .x0  (x0),
        .x1  (x1),
        .x2  (x2),
        .x3  (x3),
        .x4  (x4),
        .x5  (x5),
        .x6  (x6),
        .x7  (x7),
        .sel (sel_q),
        .y   (o_data)
    );

    assign busy    = (state_q == ST_BUSY);
    assign o_valid = busy & req[sel_q];
    assign o_last  = last[sel_q] & o_valid;
    assign xfer    = o_valid & o_ready;
    assign cnt_inc = cnt_q + 1'b1;

    assign grant = grant_q;
    assign sel   = sel_q;

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        sel_d   = sel_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            ST_IDLE: begin
                if (pick_found) begin
                    grant_d           = '0;
                    grant_d[pick_idx] = 1'b1;
                    sel_d             = pick_idx;
                    cnt_d             = '0;
                    state_d           = ST_BUSY;
                end
            end
            ST_BUSY: begin
                // A withdrawn request or a burst-ending transfer both free the bus.
                if (!req[sel_q] || (xfer && (last[sel_q] || cnt_inc == MaxHoldC))) begin
                    grant_d = '0;
                    ptr_d   = sel_q + 1'b1;
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                end else if (xfer) begin
                    cnt_d = cnt_inc;
                end
            end
            default: begin
                state_d = ST_IDLE;
                grant_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            grant_q <= '0;
            sel_q   <= '0;
            ptr_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            sel_q   <= sel_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: tb/tb_rr_bus_arbiter8.sv
// Directed-vector bench for rr_bus_arbiter8 with hand-computed expectations.
module tb_rr_bus_arbiter8;

    logic        clk;
    logic        rst_n;
    logic [7:0]  req;
    logic [7:0]  last;
    logic [31:0] xv [8];
    logic        o_ready;
    logic [7:0]  grant;
    logic [2:0]  sel;
    logic        o_valid;
    logic [31:0] o_data;
    logic        o_last;

    int n_cmp;
    int n_err;

    rr_bus_arbiter8 #(
        .DW       (32),
        .MAX_HOLD (4)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (req),
        .last    (last),
        .x0      (xv[0]),
        .x1      (xv[1]),
        .x2      (xv[2]),
        .x3      (xv[3]),
        .x4      (xv[4]),
        .x5      (xv[5]),
        .x6      (xv[6]),
        .x7      (xv[7]),
        .o_ready (o_ready),
        .grant   (grant),
        .sel     (sel),
        .o_valid (o_valid),
        .o_data  (o_data),
        .o_last  (o_last)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [7:0] exp_g;
        n_cmp   = 0;
        n_err   = 0;
        rst_n   = 1'b0;
        req     = 8'hFF;
        last    = 8'h00;
        o_ready = 1'b1;
        for (int i = 0; i < 8; i++) xv[i] = 32'hA5A5_0000 | (32'(i) << 4) | 32'(i);

        // 1: reset held, requests toggling
        for (int i = 0; i < 3; i++) begin
            tick();
            check_eq("rst_grant", 32'(grant), 32'h0);
            check_eq("rst_sel", 32'(sel), 32'h0);
            check_eq("rst_valid", 32'(o_valid), 32'h0);
            check_eq("rst_last", 32'(o_last), 32'h0);
            req = (i % 2 == 0) ? 8'h00 : 8'hFF;
        end
        req = 8'h00;
        @(negedge clk);
        rst_n = 1'b1;

        // 2: single-beat burst on 2, lone re-grant, then ptr=3 check
        req  = 8'h04;
        last = 8'h04;
        tick();
        check_eq("t2_grant", 32'(grant), 32'h04);
        check_eq("t2_sel", 32'(sel), 32'd2);
        check_eq("t2_valid", 32'(o_valid), 32'h1);
        check_eq("t2_last", 32'(o_last), 32'h1);
        check_eq("t2_data", o_data, xv[2]);
        tick();
        check_eq("t2_bubble", 32'(grant), 32'h0);
        check_eq("t2_bub_valid", 32'(o_valid), 32'h0);
        tick();
        check_eq("t2_regrant", 32'(grant), 32'h04);
        req = 8'h00;
        tick();
        check_eq("t2_withdraw", 32'(grant), 32'h0);
        req = 8'h09;
        tick();
        check_eq("t2_ptr3", 32'(grant), 32'h08);
        req  = 8'h00;
        last = 8'h00;
        tick();
        check_eq("t2_rel", 32'(grant), 32'h0);

        // back to ptr=0 for the full rotation
        rst_n = 1'b0;
        #1;
        @(negedge clk);
        rst_n = 1'b1;

        // 3: all requesting, MAX_HOLD=4 beats each, order 0..7,0
        req = 8'hFF;
        for (int g = 0; g < 9; g++) begin
            exp_g = 8'h01 << (g % 8);
            tick();
            for (int b = 0; b < 4; b++) begin
                check_eq($sformatf("t3_grant_g%0d_b%0d", g, b), 32'(grant), 32'(exp_g));
                check_eq($sformatf("t3_valid_g%0d_b%0d", g, b), 32'(o_valid), 32'h1);
                check_eq($sformatf("t3_data_g%0d_b%0d", g, b), o_data, xv[g % 8]);
                tick();
            end
            check_eq($sformatf("t3_bubble_g%0d", g), 32'(grant), 32'h0);
            check_eq($sformatf("t3_bub_valid_g%0d", g), 32'(o_valid), 32'h0);
        end
        req = 8'h00;
        tick();

        // 4: stall on 5, cnt must not advance while o_ready=0
        req = 8'h20;
        tick();
        o_ready = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
            check_eq("t4_sel", 32'(sel), 32'd5);
            check_eq("t4_data", o_data, xv[5]);
            check_eq("t4_valid", 32'(o_valid), 32'h1);
            check_eq("t4_grant", 32'(grant), 32'h20);
            tick();
        end
        o_ready = 1'b1;
        for (int b = 0; b < 4; b++) begin
            check_eq($sformatf("t4_hold_b%0d", b), 32'(grant), 32'h20);
            tick();
        end
        check_eq("t4_rel", 32'(grant), 32'h0);
        req = 8'h00;
        tick();

        // 5: grant on 7, withdraw mid-burst, wrap to 1
        req = 8'h80;
        tick();
        check_eq("t5_grant", 32'(grant), 32'h80);
        check_eq("t5_sel", 32'(sel), 32'd7);
        tick();
        req = 8'h02;
        #1;
        check_eq("t5_drop_valid", 32'(o_valid), 32'h0);
        check_eq("t5_drop_grant", 32'(grant), 32'h80);
        tick();
        check_eq("t5_rel", 32'(grant), 32'h0);
        tick();
        check_eq("t5_wrap", 32'(grant), 32'h02);
        check_eq("t5_wrap_sel", 32'(sel), 32'd1);
        req = 8'h00;
        tick();
        check_eq("t5_rel2", 32'(grant), 32'h0);

        // 6: async reset mid-burst on 3, ptr returns to 0
        req = 8'h08;
        tick();
        check_eq("t6_grant", 32'(grant), 32'h08);
        tick();
        rst_n = 1'b0;
        #1;
        check_eq("t6_async_grant", 32'(grant), 32'h0);
        check_eq("t6_async_sel", 32'(sel), 32'h0);
        check_eq("t6_async_valid", 32'(o_valid), 32'h0);
        req = 8'h88;
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        check_eq("t6_after", 32'(grant), 32'h08);
        check_eq("t6_after_sel", 32'(sel), 32'd3);
        req = 8'h00;
        tick();
        check_eq("t6_rel", 32'(grant), 32'h0);
        req = 8'h08;
        tick();
        check_eq("t6_grant2", 32'(grant), 32'h08);
        rst_n = 1'b0;
        #1;
        check_eq("t6_async2", 32'(grant), 32'h0);
        req = 8'h81;
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        check_eq("t6_ptr0", 32'(grant), 32'h01);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
